// File: rtl/igbt_fb_monitor.sv
// igbt_fb_monitor: gate-drive feedback monitor measuring on-time and latching timeout/desat faults
// into a per-channel kill mask.
module igbt_fb_monitor #(
  parameter int CLK_PER_US = 50,
  parameter int FB_TMO_CYC = 100,
  parameter int DESAT_FILT = 10,
  parameter int W          = 24
) (
  input  logic         sys_clk,
  input  logic         sys_rst_n,
  input  logic [4:0]   igbt_drive,
  input  logic [4:0]   igbt_fb,
  input  logic [4:0]   igbt_desat_n,
  input  logic [4:0]   fault_clr,
  input  logic [2:0]   rd_sel,
  output logic [4:0]   fault,
  output logic [4:0]   meas_done,
  output logic [W-1:0] rd_width,
  output logic [1:0]   rd_ftype
);
  localparam int TW = $clog2(CLK_PER_US);
  localparam int MW = $clog2(FB_TMO_CYC);
  localparam int DW = $clog2(DESAT_FILT + 1);
  typedef enum logic [2:0] {IDLE, WAIT_ON, ON, WAIT_OFF, FAULT} state_t;
  logic [4:0] fb_m_q, fb_s_q, ds_m_q, ds_s_q;
  logic [TW-1:0] tcnt_q, tcnt_d;
  logic tick;
  logic [2:0] sel;
  logic [4:0][W-1:0] wid_all;
  logic [4:0][1:0] ft_all;
  logic [W-1:0] rd_width_q, rd_width_d;
  logic [1:0] rd_ftype_q, rd_ftype_d;
  always_comb begin
    tick = tcnt_q == TW'(CLK_PER_US - 1);
    tcnt_d = tick ? '0 : tcnt_q + 1'b1;
    sel = rd_sel > 3'd4 ? 3'd0 : rd_sel;
    rd_width_d = wid_all[sel];
    rd_ftype_d = ft_all[sel];
  end
  // desat sync resets to the inactive level so no spurious low run follows reset
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      fb_m_q <= '0;
      fb_s_q <= '0;
      ds_m_q <= '1;
      ds_s_q <= '1;
      tcnt_q <= '0;
      rd_width_q <= '0;
      rd_ftype_q <= '0;
    end else begin
      fb_m_q <= igbt_fb;
      fb_s_q <= fb_m_q;
      ds_m_q <= igbt_desat_n;
      ds_s_q <= ds_m_q;
      tcnt_q <= tcnt_d;
      rd_width_q <= rd_width_d;
      rd_ftype_q <= rd_ftype_d;
    end
  end
  assign rd_width = rd_width_q;
  assign rd_ftype = rd_ftype_q;
  for (genvar i = 0; i < 5; i++) begin : g_ch
    state_t st_q, st_d;
    logic [MW-1:0] tmo_q, tmo_d;
    logic [DW-1:0] dc_q, dc_d;
    logic [W-1:0] wc_q, wc_d, wid_q, wid_d, wc_inc;
    logic [1:0] ft_q, ft_d;
    logic done_q, done_d;
    logic drv, fbs, dsn, act, dhit, thit;
    assign drv = igbt_drive[i];
    assign fbs = fb_s_q[i];
    assign dsn = ds_s_q[i];
    always_comb begin
      act = st_q inside {WAIT_ON, ON, WAIT_OFF};
      dhit = act && !dsn && dc_q == DW'(DESAT_FILT - 1);
      thit = tmo_q == MW'(FB_TMO_CYC - 1);
      wc_inc = (tick && wc_q != '1) ? wc_q + 1'b1 : wc_q;
      dc_d = (act && !dsn) ? dc_q + 1'b1 : '0;
      st_d = st_q;
      tmo_d = '0;
      wc_d = wc_q;
      wid_d = wid_q;
      ft_d = ft_q;
      done_d = 1'b0;
      if (dhit) begin
        st_d = FAULT;
        ft_d = 2'b11;
      end else begin
        case (st_q)
          IDLE:
            if (drv) st_d = WAIT_ON;
            else if (fbs && thit) begin
              st_d = FAULT;
              ft_d = 2'b10;
            end else if (fbs) tmo_d = tmo_q + 1'b1;
          WAIT_ON:
            if (!drv) st_d = IDLE;
            else if (fbs) begin
              st_d = ON;
              wc_d = '0;
            end else if (thit) begin
              st_d = FAULT;
              ft_d = 2'b01;
            end else tmo_d = tmo_q + 1'b1;
          ON:
            if (drv && !fbs) begin
              st_d = FAULT;
              ft_d = 2'b01;
            end else if (!fbs) begin
              st_d = IDLE;
              wid_d = wc_q;
              done_d = 1'b1;
            end else begin
              wc_d = wc_inc;
              st_d = drv ? ON : WAIT_OFF;
            end
          WAIT_OFF:
            if (!fbs) begin
              st_d = IDLE;
              wid_d = wc_q;
              done_d = 1'b1;
            end else if (thit) begin
              st_d = FAULT;
              ft_d = 2'b10;
            end else begin
              tmo_d = tmo_q + 1'b1;
              wc_d = wc_inc;
            end
          FAULT:
            if (fault_clr[i] && !drv && !fbs && dsn) begin
              st_d = IDLE;
              ft_d = 2'b00;
            end
          default: st_d = IDLE;
        endcase
      end
    end
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
        st_q <= IDLE;
        tmo_q <= '0;
        dc_q <= '0;
        wc_q <= '0;
        wid_q <= '0;
        ft_q <= '0;
        done_q <= 1'b0;
      end else begin
        st_q <= st_d;
        tmo_q <= tmo_d;
        dc_q <= dc_d;
        wc_q <= wc_d;
        wid_q <= wid_d;
        ft_q <= ft_d;
        done_q <= done_d;
      end
    end
    assign fault[i] = st_q == FAULT;
    assign meas_done[i] = done_q;
    assign wid_all[i] = wid_q;
    assign ft_all[i] = ft_q;
  end
endmodule

// File: tb/tb_igbt_fb_monitor.sv
// tb_igbt_fb_monitor: directed scenarios plus random traffic, checked every cycle against a
// behavioural channel model.
module tb_igbt_fb_monitor;
  localparam int CPU = 50, TMO = 100, DF = 10, W = 24;
  localparam int MAXW = (1 << W) - 1;
  localparam int S_IDLE = 0, S_WON = 1, S_ON = 2, S_WOFF = 3, S_FLT = 4;
  logic clk = 1'b0, rst_n = 1'b0;
  logic [4:0] drive = '0, fb = '0, desat_n = '1, clr = '0;
  logic [2:0] rd_sel = '0;
  logic [4:0] fault, meas_done;
  logic [W-1:0] rd_width;
  logic [1:0] rd_ftype;
  int errors = 0, checks = 0;
  bit echo[5];
  int dly[5];
  logic [63:0] hist[5];
  int m_st[5], m_wait[5], m_low[5], m_us[5], m_wid[5], m_ft[5];
  bit m_done[5], fs1[5], fs2[5], ds1[5], ds2[5];
  int m_phase, m_rdw, m_rdt;
  logic [4:0] mf, md;

  igbt_fb_monitor dut (
    .sys_clk(clk), .sys_rst_n(rst_n), .igbt_drive(drive), .igbt_fb(fb),
    .igbt_desat_n(desat_n), .fault_clr(clr), .rd_sel(rd_sel), .fault(fault),
    .meas_done(meas_done), .rd_width(rd_width), .rd_ftype(rd_ftype)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input longint act, input longint lo, input longint hi);
    checks++;
    if (act < lo || act > hi) begin
      errors++;
      $display("FAIL %s: got %0d, want %0d..%0d at %0t", name, act, lo, hi, $time);
    end
  endtask

  task automatic model_step();
    int s;
    bit tk;
    if (!rst_n) begin
      for (int c = 0; c < 5; c++) begin
        m_st[c] = S_IDLE; m_wait[c] = 0; m_low[c] = 0; m_us[c] = 0; m_wid[c] = 0; m_ft[c] = 0;
        m_done[c] = 0; fs1[c] = 0; fs2[c] = 0; ds1[c] = 1; ds2[c] = 1;
      end
      m_phase = 0; m_rdw = 0; m_rdt = 0;
      return;
    end
    s = rd_sel > 3'd4 ? 0 : int'(rd_sel);
    m_rdw = m_wid[s];
    m_rdt = m_ft[s];
    tk = m_phase == CPU - 1;
    m_phase = (m_phase + 1) % CPU;
    for (int c = 0; c < 5; c++) begin
      bit d, f, dn, live;
      int nxt;
      d = drive[c]; f = fs2[c]; dn = ds2[c];
      m_done[c] = 0;
      nxt = m_st[c];
      live = m_st[c] == S_WON || m_st[c] == S_ON || m_st[c] == S_WOFF;
      m_low[c] = (live && !dn) ? m_low[c] + 1 : 0;
      if (live && m_low[c] == DF) begin
        nxt = S_FLT; m_ft[c] = 3;
      end else begin
        case (m_st[c])
          S_IDLE:
            if (d) nxt = S_WON;
            else if (f) begin
              m_wait[c]++;
              if (m_wait[c] == TMO) begin nxt = S_FLT; m_ft[c] = 2; end
            end else m_wait[c] = 0;
          S_WON:
            if (!d) nxt = S_IDLE;
            else if (f) begin nxt = S_ON; m_us[c] = 0; end
            else begin
              m_wait[c]++;
              if (m_wait[c] == TMO) begin nxt = S_FLT; m_ft[c] = 1; end
            end
          S_ON:
            if (d && !f) begin nxt = S_FLT; m_ft[c] = 1; end
            else if (!f) begin nxt = S_IDLE; m_wid[c] = m_us[c]; m_done[c] = 1; end
            else begin
              m_us[c] = m_us[c] + int'(tk) > MAXW ? MAXW : m_us[c] + int'(tk);
              if (!d) nxt = S_WOFF;
            end
          S_WOFF:
            if (!f) begin nxt = S_IDLE; m_wid[c] = m_us[c]; m_done[c] = 1; end
            else begin
              m_wait[c]++;
              if (m_wait[c] == TMO) begin nxt = S_FLT; m_ft[c] = 2; end
              else m_us[c] = m_us[c] + int'(tk) > MAXW ? MAXW : m_us[c] + int'(tk);
            end
          default:
            if (clr[c] && !d && !f && dn) begin nxt = S_IDLE; m_ft[c] = 0; end
        endcase
      end
      if (nxt != m_st[c]) m_wait[c] = 0;
      m_st[c] = nxt;
      fs2[c] = fs1[c]; fs1[c] = fb[c];
      ds2[c] = ds1[c]; ds1[c] = desat_n[c];
    end
  endtask

  initial forever begin
    @(posedge clk or negedge rst_n);
    model_step();
    @(negedge clk);
    for (int c = 0; c < 5; c++) begin
      mf[c] = m_st[c] == S_FLT;
      md[c] = m_done[c];
    end
    chk("fault", fault, mf, mf);
    chk("meas_done", meas_done, md, md);
    chk("rd_width", rd_width, m_rdw, m_rdw);
    chk("rd_ftype", rd_ftype, m_rdt, m_rdt);
  end

  task automatic cyc();
    @(negedge clk);
    for (int c = 0; c < 5; c++) begin
      hist[c] = {hist[c][62:0], drive[c]};
      if (echo[c]) fb[c] = hist[c][dly[c]];
    end
  endtask

  task automatic wait_bit(input int ch, input bit is_fault, input int maxc, output int n);
    n = 0;
    while (n < maxc) begin
      cyc();
      n++;
      if (is_fault ? fault[ch] : meas_done[ch]) return;
    end
    checks++;
    errors++;
    $display("FAIL wait_ch%0d: event absent after %0d cycles, want within %0d", ch, n, maxc);
    n = -1;
  endtask

  initial begin
    int n, cd[5], dlow[5];
    bit got0, got4;
    for (int c = 0; c < 5; c++) begin echo[c] = 0; dly[c] = 0; hist[c] = '0; end
    repeat (3) cyc();
    #1 rst_n = 1'b1;
    // 1: store a width on ch2, then reset in the middle of a second pulse
    echo[2] = 1; dly[2] = 3; rd_sel = 3'd2;
    drive[2] = 1; repeat (150) cyc();
    drive[2] = 0; wait_bit(2, 0, 50, n);
    cyc();
    chk("t1_prior_width", rd_width, 1, 3);
    drive[2] = 1; repeat (60) cyc();
    #1 rst_n = 1'b0;
    cyc();
    chk("t1_rst_fault", fault, 0, 0);
    chk("t1_rst_md", meas_done, 0, 0);
    chk("t1_rst_width", rd_width, 0, 0);
    drive[2] = 0; repeat (5) cyc();
    #1 rst_n = 1'b1;
    repeat (10) cyc();
    chk("t1_idle_ftype", rd_ftype, 0, 0);
    echo[2] = 0; fb[2] = 0;
    // 2: 10 us pulse with 20-cycle echo on both edges
    echo[0] = 1; dly[0] = 20; rd_sel = 3'd0;
    drive[0] = 1; repeat (500) cyc();
    drive[0] = 0; wait_bit(0, 0, 200, n);
    cyc();
    chk("t2_width", rd_width, 9, 10);
    chk("t2_md_single", meas_done[0], 0, 0);
    chk("t2_fault", fault, 0, 0);
    // 3: feedback never rises on ch1
    fb[1] = 0; drive[1] = 1;
    wait_bit(1, 1, 200, n);
    chk("t3_latency", n, TMO, TMO + 3);
    rd_sel = 3'd1; cyc();
    chk("t3_ftype", rd_ftype, 1, 1);
    clr[1] = 1; cyc(); clr[1] = 0; cyc();
    chk("t3_clr_ignored", fault[1], 1, 1);
    drive[1] = 0; repeat (3) cyc();
    clr[1] = 1; cyc(); clr[1] = 0; cyc();
    chk("t3_cleared", fault[1], 0, 0);
    // 4: desat filter on ch3, then desat coincident with feedback loss
    echo[3] = 1; dly[3] = 4; drive[3] = 1; repeat (30) cyc();
    desat_n[3] = 0; repeat (DF - 1) cyc();
    desat_n[3] = 1; repeat (5) cyc();
    chk("t4_short_desat", fault[3], 0, 0);
    desat_n[3] = 0; repeat (DF - 1) cyc();
    echo[3] = 0; fb[3] = 0; cyc();
    repeat (5) cyc();
    chk("t4_desat_fault", fault[3], 1, 1);
    rd_sel = 3'd3; cyc();
    chk("t4_ftype", rd_ftype, 3, 3);
    drive[3] = 0; desat_n[3] = 1; repeat (5) cyc();
    clr[3] = 1; cyc(); clr[3] = 0; cyc();
    chk("t4_cleared", fault, 0, 0);
    // 5: unexpected feedback on ch4 for exactly the timeout
    fb[4] = 1; repeat (TMO) cyc();
    fb[4] = 0; repeat (5) cyc();
    chk("t5_fault_mask", fault, 5'h10, 5'h10);
    rd_sel = 3'd4; cyc();
    chk("t5_ftype", rd_ftype, 2, 2);
    clr[4] = 1; cyc(); clr[4] = 0; cyc();
    chk("t5_cleared", fault, 0, 0);
    // 6: concurrent 5 us and 7 us pulses on ch0 and ch4
    echo[0] = 1; dly[0] = 5; echo[4] = 1; dly[4] = 9;
    drive[0] = 1; drive[4] = 1; got0 = 0; got4 = 0;
    for (int k = 0; k < 600 && !(got0 && got4); k++) begin
      if (k == 250) drive[0] = 0;
      if (k == 350) drive[4] = 0;
      cyc();
      if (meas_done[0]) got0 = 1;
      if (meas_done[4]) got4 = 1;
    end
    chk("t6_md0", got0, 1, 1);
    chk("t6_md4", got4, 1, 1);
    rd_sel = 3'd0; cyc();
    chk("t6_width0", rd_width, 4, 5);
    rd_sel = 3'd4; cyc();
    chk("t6_width4", rd_width, 6, 7);
    rd_sel = 3'd6; cyc();
    chk("t6_sel6", rd_width, 4, 5);
    // random traffic: echoes, stuck feedback, desat bursts, clears
    for (int c = 0; c < 5; c++) begin cd[c] = $urandom_range(300, 1); dlow[c] = 0; end
    for (int k = 0; k < 20000; k++) begin
      for (int c = 0; c < 5; c++) begin
        if (cd[c] == 0) begin
          drive[c] = ~drive[c];
          cd[c] = $urandom_range(600, 20);
          if (drive[c]) begin
            echo[c] = $urandom_range(9, 0) != 0;
            dly[c] = $urandom_range(30, 0);
            if (!echo[c]) fb[c] = 1'($urandom_range(1, 0));
          end
        end else cd[c]--;
        if (dlow[c] > 0) begin
          dlow[c]--;
          desat_n[c] = 0;
        end else begin
          desat_n[c] = 1;
          if ($urandom_range(399, 0) == 0) dlow[c] = $urandom_range(14, 1);
        end
        clr[c] = $urandom_range(29, 0) == 0;
      end
      rd_sel = 3'($urandom_range(7, 0));
      cyc();
    end
    for (int c = 0; c < 5; c++) begin echo[c] = 0; end
    drive = '0; fb = '0; desat_n = '1; clr = '0;
    repeat (200) cyc();
    clr = '1; cyc(); clr = '0; repeat (3) cyc();
    chk("end_all_clear", fault, 0, 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
